// File: rtl/octal_disp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | octal_disp_pkg : segment constants and digit-count helper            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package octal_disp_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic int num_digits(input int data_w);
        return (data_w + 2) / 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/octal_seg_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | octal_seg_decoder : octal digit to gfedcba pattern, no polarity      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module octal_seg_decoder
    import octal_disp_pkg::*;
(
    input  logic [2:0] i_digit,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                3'd0: o_seg = SEG_0;
                3'd1: o_seg = SEG_1;
                3'd2: o_seg = SEG_2;
                3'd3: o_seg = SEG_3;
                3'd4: o_seg = SEG_4;
                3'd5: o_seg = SEG_5;
                3'd6: o_seg = SEG_6;
                3'd7: o_seg = SEG_7;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/octal_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | octal_scan_display : multiplexed multi-digit octal 7-segment driver  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module octal_scan_display
    import octal_disp_pkg::*;
#(
    parameter  int DATA_W         = 12,
    parameter  int REFRESH_DIV    = 1000,
    parameter  bit BLANK_LZ       = 1'b1,
    parameter  bit SEG_ACTIVE_LOW = 1'b0,
    parameter  bit DIG_ACTIVE_LOW = 1'b0,
    localparam int NUM_DIGITS     = num_digits(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     data_in,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PAD_W = 3 * NUM_DIGITS;

    localparam logic [CNT_W-1:0]      c_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            c_SEG_INV  = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] c_DIG_INV  = {NUM_DIGITS{DIG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] c_DIG_0    = NUM_DIGITS'(1);

    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_shown;
    logic [DATA_W-1:0]     r_pending;
    logic                  r_pend_full;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_dig;
    logic                  r_frame;

    logic                  w_adv;
    logic                  w_wrap;
    logic                  w_accept;
    logic [IDX_W-1:0]      w_idx_nx;
    logic [DATA_W-1:0]     w_shown_nx;
    logic [PAD_W-1:0]      w_pad;
    logic [2:0]            w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_hi_zero;
    logic                  w_blank;
    logic [6:0]            w_seg_raw;
    logic [NUM_DIGITS-1:0] w_dig_nx;

    assign w_adv    = (r_cnt == c_CNT_LAST);
    assign w_wrap   = w_adv && (r_idx == c_IDX_LAST);
    assign w_accept = in_valid && !r_pend_full;
    assign in_ready = !r_pend_full;

    always_comb begin
        w_idx_nx = r_idx;
        if (w_adv) begin
            w_idx_nx = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Outputs are decoded from the next-state value so the new frame's
    // first digit already reflects the freshly promoted pending data.
    assign w_shown_nx = (w_wrap && r_pend_full) ? r_pending : r_shown;
    assign w_pad      = PAD_W'(w_shown_nx);

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
            assign w_digit[k]   = w_pad[3*k +: 3];
            assign w_hi_zero[k] = ~|w_pad[PAD_W-1:3*k];
        end
    endgenerate

    assign w_blank  = BLANK_LZ && (w_idx_nx != '0) && w_hi_zero[w_idx_nx];
    assign w_dig_nx = c_DIG_0 << w_idx_nx;

    octal_seg_decoder u_dec (
        .i_digit (w_digit[w_idx_nx]),
        .i_blank (w_blank),
        .o_seg   (w_seg_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shown     <= '0;
            r_pending   <= '0;
            r_pend_full <= 1'b0;
            r_seg       <= SEG_0 ^ c_SEG_INV;
            r_dig       <= c_DIG_0 ^ c_DIG_INV;
            r_frame     <= 1'b0;
        end else begin
            r_cnt   <= w_adv ? '0 : r_cnt + 1'b1;
            r_idx   <= w_idx_nx;
            r_shown <= w_shown_nx;
            if (w_wrap && r_pend_full) begin
                r_pend_full <= 1'b0;
            end
            if (w_accept) begin
                r_pending   <= data_in;
                r_pend_full <= 1'b1;
            end
            r_seg   <= w_seg_raw ^ c_SEG_INV;
            r_dig   <= w_dig_nx ^ c_DIG_INV;
            r_frame <= w_wrap;
        end
    end

    assign seg_out    = r_seg;
    assign dig_en     = r_dig;
    assign frame_tick = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_octal_scan_display.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_octal_scan_display : four parameter variants vs. timing model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_octal_scan_display;

    localparam int NI = 4;
    localparam int P_DW  [NI] = '{12, 12, 12, 8};
    localparam int P_DIV [NI] = '{4, 4, 4, 1};
    localparam int P_BLZ [NI] = '{1, 0, 1, 1};
    localparam int P_SAL [NI] = '{0, 0, 1, 0};
    localparam int P_DAL [NI] = '{0, 0, 1, 0};
    localparam logic [6:0] SEG_TAB [8] =
        '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] data_in;
    logic [NI-1:0] rdy;
    logic [NI-1:0] frm;
    logic [6:0]  seg [NI];
    logic [3:0]  dig [NI];
    logic [2:0]  dig3;

    int          m_cyc   [NI];
    logic [11:0] m_shown [NI];
    logic [11:0] m_pend  [NI];
    bit          m_full  [NI];
    bit          acc0;
    int          n_checks;
    int          n_fail;

    octal_scan_display #(.DATA_W(12), .REFRESH_DIV(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .data_in(data_in), .seg_out(seg[0]), .dig_en(dig[0]), .frame_tick(frm[0]));

    octal_scan_display #(.DATA_W(12), .REFRESH_DIV(4), .BLANK_LZ(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .data_in(data_in), .seg_out(seg[1]), .dig_en(dig[1]), .frame_tick(frm[1]));

    octal_scan_display #(.DATA_W(12), .REFRESH_DIV(4),
                         .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .data_in(data_in), .seg_out(seg[2]), .dig_en(dig[2]), .frame_tick(frm[2]));

    octal_scan_display #(.DATA_W(8), .REFRESH_DIV(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[3]),
        .data_in(data_in[7:0]), .seg_out(seg[3]), .dig_en(dig3), .frame_tick(frm[3]));

    assign dig[3] = {1'b0, dig3};

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_cyc[i]   = 0;
            m_shown[i] = '0;
            m_pend[i]  = '0;
            m_full[i]  = 1'b0;
        end
    endtask

    // One clock edge of each variant: time-based scan position plus a
    // single-entry pending slot that is promoted only at frame boundaries.
    task automatic model_step(input bit v, input logic [11:0] d);
        int  nd;
        int  mask;
        bit  acc;
        bit  wrap;
        for (int i = 0; i < NI; i++) begin
            nd   = (P_DW[i] + 2) / 3;
            mask = (1 << P_DW[i]) - 1;
            acc  = v && !m_full[i];
            m_cyc[i]++;
            wrap = (m_cyc[i] % (P_DIV[i] * nd)) == 0;
            if (wrap && m_full[i]) begin
                m_shown[i] = m_pend[i];
                m_full[i]  = 1'b0;
            end
            if (acc) begin
                m_pend[i] = d & mask[11:0];
                m_full[i] = 1'b1;
            end
            if (i == 0) acc0 = acc;
        end
    endtask

    task automatic check_all();
        int nd, idx, rest, es, ed;
        bit blank, ef;
        for (int i = 0; i < NI; i++) begin
            nd    = (P_DW[i] + 2) / 3;
            idx   = (m_cyc[i] / P_DIV[i]) % nd;
            rest  = int'(m_shown[i]) >> (3 * idx);
            blank = (P_BLZ[i] != 0) && (idx > 0) && (rest == 0);
            es    = blank ? 0 : int'(SEG_TAB[rest & 7]);
            if (P_SAL[i] != 0) es = es ^ 32'h7F;
            ed    = 1 << idx;
            if (P_DAL[i] != 0) ed = ed ^ ((1 << nd) - 1);
            ef    = (m_cyc[i] > 0) && ((m_cyc[i] % (P_DIV[i] * nd)) == 0);
            check_val($sformatf("seg_out[%0d]", i), 32'(seg[i]), es);
            check_val($sformatf("dig_en[%0d]", i), 32'(dig[i]), ed);
            check_val($sformatf("frame_tick[%0d]", i), 32'(frm[i]), 32'(ef));
            check_val($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(!m_full[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step(in_valid, data_in);
        check_all();
    endtask

    task automatic reset_running();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic reset_stopped();
        @(negedge clk);
        clk_en = 1'b0;
        #12 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #6 rst_n = 1'b1;
        #2 clk_en = 1'b1;
    endtask

    logic [11:0] dir_val [5];
    int          dir_gap [5];
    int          n;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        acc0     = 1'b0;
        clk_en   = 1'b0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        dir_val  = '{12'o1234, 12'o0007, 12'o0000, 12'o0001, 12'o7777};
        dir_gap  = '{36, 36, 36, 0, 36};

        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3 rst_n = 1'b1;
        #1 clk_en = 1'b1;

        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            data_in  = dir_val[k];
            n = 0;
            do begin
                step();
                n++;
            end while (!acc0 && n < 100);
            check_val("accept_directed", 32'(acc0), 32'd1);
            in_valid = 1'b0;
            repeat (dir_gap[k]) step();
        end

        n = 0;
        while (((m_cyc[0] + 1) % 16) != 0 && n < 32) begin
            step();
            n++;
        end
        in_valid = 1'b1;
        data_in  = 12'o4321;
        step();
        in_valid = 1'b0;
        check_val("accept_on_wrap", 32'(acc0), 32'd1);
        repeat (40) step();

        in_valid = 1'b1;
        data_in  = 12'o5555;
        n = 0;
        do begin
            step();
            n++;
        end while (!acc0 && n < 100);
        check_val("accept_before_reset", 32'(acc0), 32'd1);
        in_valid = 1'b0;
        repeat (5) step();
        reset_running();
        repeat (40) step();
        reset_stopped();

        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) == 0);
            data_in  = 12'($urandom);
            step();
            if ($urandom_range(0, 199) == 0) reset_running();
            if (c == 700) reset_stopped();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
